// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared widths, types and lowest-index helper for the CAM
package cam_pkg;

   localparam int CAM_DATA_WIDTH = 32;
   localparam int CAM_ADDR_WIDTH = 5;
   localparam int CAM_MAX_DEPTH  = 256;

   typedef logic [CAM_ADDR_WIDTH-1:0] cam_index_t;
   typedef logic [CAM_DATA_WIDTH-1:0] cam_data_t;
   typedef logic [CAM_ADDR_WIDTH:0]   cam_count_t;

   // Reference encoder: lowest set bit position, 0 when the vector is empty.
   function automatic int cam_lowest_index(input logic [CAM_MAX_DEPTH-1:0] vec);
      int idx;
      idx = 0;
      for (int i = CAM_MAX_DEPTH - 1; i >= 0; i--) begin
         if (vec[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/cam_core_if.sv
// rtl/cam_core_if.sv - request/response bundle between lookup controller and CAM
interface cam_core_if
   import cam_pkg::*;
#(
   parameter int DATA_WIDTH = CAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
);
   logic                  write_en_i;
   logic [ADDR_WIDTH-1:0] write_index_i;
   logic [DATA_WIDTH-1:0] write_data_i;
   logic                  inv_en_i;
   logic [ADDR_WIDTH-1:0] inv_index_i;
   logic                  read_en_i;
   logic [ADDR_WIDTH-1:0] read_index_i;
   logic                  read_valid_o;
   logic [DATA_WIDTH-1:0] read_value_o;
   logic                  search_en_i;
   logic [DATA_WIDTH-1:0] search_data_i;
   logic                  search_resp_o;
   logic                  search_hit_o;
   logic [ADDR_WIDTH-1:0] search_index_o;
   logic [ADDR_WIDTH:0]   count_o;
   logic                  full_o;
   logic                  empty_o;

   modport master (
      output write_en_i, write_index_i, write_data_i,
      output inv_en_i, inv_index_i,
      output read_en_i, read_index_i,
      output search_en_i, search_data_i,
      input  read_valid_o, read_value_o,
      input  search_resp_o, search_hit_o, search_index_o,
      input  count_o, full_o, empty_o
   );

   modport slave (
      input  write_en_i, write_index_i, write_data_i,
      input  inv_en_i, inv_index_i,
      input  read_en_i, read_index_i,
      input  search_en_i, search_data_i,
      output read_valid_o, read_value_o,
      output search_resp_o, search_hit_o, search_index_o,
      output count_o, full_o, empty_o
   );
endinterface

// File: rtl/cam_prio_enc.sv
// rtl/cam_prio_enc.sv - combinational lowest-index priority encoder with hit flag
module cam_prio_enc #(
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic [DEPTH-1:0]      match_i,
   output logic                  hit_o,
   output logic [ADDR_WIDTH-1:0] index_o
);
   // Scan from the top so the lowest set bit is the last one to land.
   always_comb begin
      hit_o   = 1'b0;
      index_o = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (match_i[i]) begin
            hit_o   = 1'b1;
            index_o = ADDR_WIDTH'(i);
         end
      end
   end
endmodule

// File: rtl/cam_core.sv
// rtl/cam_core.sv - CAM with valid bits, occupancy count, registered read and search
module cam_core
   import cam_pkg::*;
#(
   parameter int DATA_WIDTH = CAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input logic       clk,
   input logic       rst,
   cam_core_if.slave bus
);
   localparam int CW = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  read_valid_q;
   logic [DATA_WIDTH-1:0] read_value_q;
   logic                  search_resp_q;
   logic                  search_hit_q;
   logic [ADDR_WIDTH-1:0] search_index_q;

   logic                  wr_ok, inv_ok, rd_ok, rd_hit, inc, dec;
   logic [DEPTH-1:0]      match;
   logic                  enc_hit;
   logic [ADDR_WIDTH-1:0] enc_index;

   assign wr_ok  = bus.write_en_i && (int'(bus.write_index_i) < DEPTH);
   assign inv_ok = bus.inv_en_i   && (int'(bus.inv_index_i)   < DEPTH);
   assign rd_ok  = bus.read_en_i  && (int'(bus.read_index_i)  < DEPTH);
   assign rd_hit = rd_ok && valid_q[bus.read_index_i];

   // Write is applied after invalidate so it wins on an index collision.
   always_comb begin
      valid_d = valid_q;
      inc     = wr_ok && !valid_q[bus.write_index_i];
      dec     = inv_ok && valid_q[bus.inv_index_i]
                && !(wr_ok && (bus.write_index_i == bus.inv_index_i));
      if (inv_ok) valid_d[bus.inv_index_i] = 1'b0;
      if (wr_ok)  valid_d[bus.write_index_i] = 1'b1;
      count_d = count_q;
      if (inc && !dec)      count_d = count_q + CW'(1);
      else if (dec && !inc) count_d = count_q - CW'(1);
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_match
      assign match[i] = valid_q[i] && (mem_q[i] == bus.search_data_i);
   end

   cam_prio_enc #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_prio_enc (
      .match_i (match),
      .hit_o   (enc_hit),
      .index_o (enc_index)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q        <= '0;
         count_q        <= '0;
         read_valid_q   <= 1'b0;
         read_value_q   <= '0;
         search_resp_q  <= 1'b0;
         search_hit_q   <= 1'b0;
         search_index_q <= '0;
      end else begin
         valid_q       <= valid_d;
         count_q       <= count_d;
         read_valid_q  <= rd_hit;
         search_resp_q <= bus.search_en_i;
         if (bus.read_en_i) read_value_q <= rd_hit ? mem_q[bus.read_index_i] : '0;
         if (bus.search_en_i) begin
            search_hit_q   <= enc_hit;
            search_index_q <= enc_index;
         end
      end
   end

   // Storage is deliberately left out of reset; only the write port touches it.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) mem_q[bus.write_index_i] <= bus.write_data_i;
   end

   always_ff @(posedge clk) begin
      if (!rst && bus.search_en_i) begin
         assert (enc_hit == (|match));
         assert (int'(enc_index) == cam_lowest_index(CAM_MAX_DEPTH'(match)));
      end
   end

   assign bus.read_valid_o   = read_valid_q;
   assign bus.read_value_o   = read_value_q;
   assign bus.search_resp_o  = search_resp_q;
   assign bus.search_hit_o   = search_hit_q;
   assign bus.search_index_o = search_index_q;
   assign bus.count_o        = count_q;
   assign bus.full_o         = (int'(count_q) == DEPTH);
   assign bus.empty_o        = (count_q == '0);
endmodule

// File: tb/tb_cam_core.sv
// tb/tb_cam_core.sv - directed self-checking bench for cam_core
module tb_cam_core;
   import cam_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   cam_core_if cif ();

   cam_core dut (
      .clk (clk),
      .rst (rst),
      .bus (cif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
      $fatal(1);
   end

   task automatic idle();
      cif.write_en_i    = 1'b0;
      cif.write_index_i = '0;
      cif.write_data_i  = '0;
      cif.inv_en_i      = 1'b0;
      cif.inv_index_i   = '0;
      cif.read_en_i     = 1'b0;
      cif.read_index_i  = '0;
      cif.search_en_i   = 1'b0;
      cif.search_data_i = '0;
   endtask

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      total++; if (cif.count_o !== 6'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", cif.count_o); end
      total++; if (cif.empty_o !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", cif.empty_o); end
      total++; if (cif.full_o !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", cif.full_o); end
      total++; if (cif.read_valid_o !== 1'b0 || cif.read_value_o !== 32'h0) begin bad++; $display("FAIL rst_read got=%b/%h exp=0/0", cif.read_valid_o, cif.read_value_o); end
      total++; if (cif.search_resp_o !== 1'b0 || cif.search_hit_o !== 1'b0 || cif.search_index_o !== 5'd0) begin bad++; $display("FAIL rst_search got=%b/%b/%0d exp=0/0/0", cif.search_resp_o, cif.search_hit_o, cif.search_index_o); end
   endtask

   task automatic test_write_read();
      cif.write_en_i = 1'b1; cif.write_index_i = 5'd3; cif.write_data_i = 32'hDEADBEEF;
      tick();
      total++; if (cif.count_o !== 6'd1 || cif.empty_o !== 1'b0) begin bad++; $display("FAIL wr_count got=%0d/%b exp=1/0", cif.count_o, cif.empty_o); end
      cif.read_en_i = 1'b1; cif.read_index_i = 5'd3;
      tick();
      total++; if (cif.read_valid_o !== 1'b1 || cif.read_value_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hit got=%b/%h exp=1/deadbeef", cif.read_valid_o, cif.read_value_o); end
      tick();
      total++; if (cif.read_valid_o !== 1'b0 || cif.read_value_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hold got=%b/%h exp=0/deadbeef", cif.read_valid_o, cif.read_value_o); end
   endtask

   task automatic test_search();
      cif.write_en_i = 1'b1; cif.write_index_i = 5'd7; cif.write_data_i = 32'h55;
      tick();
      cif.write_en_i = 1'b1; cif.write_index_i = 5'd2; cif.write_data_i = 32'h55;
      tick();
      cif.search_en_i = 1'b1; cif.search_data_i = 32'h55;
      tick();
      total++; if (cif.search_resp_o !== 1'b1 || cif.search_hit_o !== 1'b1 || cif.search_index_o !== 5'd2) begin bad++; $display("FAIL srch_low got=%b/%b/%0d exp=1/1/2", cif.search_resp_o, cif.search_hit_o, cif.search_index_o); end
      cif.inv_en_i = 1'b1; cif.inv_index_i = 5'd2;
      tick();
      total++; if (cif.search_resp_o !== 1'b0 || cif.search_hit_o !== 1'b1 || cif.search_index_o !== 5'd2) begin bad++; $display("FAIL srch_hold got=%b/%b/%0d exp=0/1/2", cif.search_resp_o, cif.search_hit_o, cif.search_index_o); end
      total++; if (cif.count_o !== 6'd2) begin bad++; $display("FAIL inv_count got=%0d exp=2", cif.count_o); end
      cif.search_en_i = 1'b1; cif.search_data_i = 32'h55;
      tick();
      total++; if (cif.search_resp_o !== 1'b1 || cif.search_hit_o !== 1'b1 || cif.search_index_o !== 5'd7) begin bad++; $display("FAIL srch_after_inv got=%b/%b/%0d exp=1/1/7", cif.search_resp_o, cif.search_hit_o, cif.search_index_o); end
   endtask

   task automatic test_same_cycle();
      cif.write_en_i = 1'b1; cif.write_index_i = 5'd4; cif.write_data_i = 32'hA;
      cif.search_en_i = 1'b1; cif.search_data_i = 32'hA;
      tick();
      total++; if (cif.search_resp_o !== 1'b1 || cif.search_hit_o !== 1'b0 || cif.search_index_o !== 5'd0) begin bad++; $display("FAIL rbw_miss got=%b/%b/%0d exp=1/0/0", cif.search_resp_o, cif.search_hit_o, cif.search_index_o); end
      cif.search_en_i = 1'b1; cif.search_data_i = 32'hA;
      tick();
      total++; if (cif.search_hit_o !== 1'b1 || cif.search_index_o !== 5'd4) begin bad++; $display("FAIL rbw_hit got=%b/%0d exp=1/4", cif.search_hit_o, cif.search_index_o); end
      total++; if (cif.count_o !== 6'd3) begin bad++; $display("FAIL rbw_count got=%0d exp=3", cif.count_o); end
   endtask

   task automatic test_write_inv_collide();
      cif.write_en_i = 1'b1; cif.write_index_i = 5'd5; cif.write_data_i = 32'h1234;
      cif.inv_en_i = 1'b1; cif.inv_index_i = 5'd5;
      tick();
      total++; if (cif.count_o !== 6'd1) begin bad++; $display("FAIL wi_count got=%0d exp=1", cif.count_o); end
      cif.read_en_i = 1'b1; cif.read_index_i = 5'd5;
      cif.write_en_i = 1'b1; cif.write_index_i = 5'd5; cif.write_data_i = 32'h77;
      tick();
      total++; if (cif.read_valid_o !== 1'b1 || cif.read_value_o !== 32'h1234) begin bad++; $display("FAIL wi_read got=%b/%h exp=1/1234", cif.read_valid_o, cif.read_value_o); end
      total++; if (cif.count_o !== 6'd1) begin bad++; $display("FAIL rewrite_count got=%0d exp=1", cif.count_o); end
      cif.read_en_i = 1'b1; cif.read_index_i = 5'd5;
      tick();
      total++; if (cif.read_value_o !== 32'h77) begin bad++; $display("FAIL rewrite_read got=%h exp=77", cif.read_value_o); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 32; i++) begin
         cif.write_en_i = 1'b1; cif.write_index_i = 5'(i); cif.write_data_i = 32'h1000 + 32'(i);
         tick();
      end
      total++; if (cif.count_o !== 6'd32 || cif.full_o !== 1'b1 || cif.empty_o !== 1'b0) begin bad++; $display("FAIL fill got=%0d/%b/%b exp=32/1/0", cif.count_o, cif.full_o, cif.empty_o); end
      cif.inv_en_i = 1'b1; cif.inv_index_i = 5'd0;
      cif.write_en_i = 1'b1; cif.write_index_i = 5'd31; cif.write_data_i = 32'h101F;
      tick();
      total++; if (cif.count_o !== 6'd31 || cif.full_o !== 1'b0) begin bad++; $display("FAIL unfill got=%0d/%b exp=31/0", cif.count_o, cif.full_o); end
      cif.inv_en_i = 1'b1; cif.inv_index_i = 5'd1;
      cif.write_en_i = 1'b1; cif.write_index_i = 5'd0; cif.write_data_i = 32'h1000;
      tick();
      total++; if (cif.count_o !== 6'd31) begin bad++; $display("FAIL net_zero got=%0d exp=31", cif.count_o); end
      cif.read_en_i = 1'b1; cif.read_index_i = 5'd1;
      cif.search_en_i = 1'b1; cif.search_data_i = 32'h1001;
      tick();
      total++; if (cif.read_valid_o !== 1'b0 || cif.read_value_o !== 32'h0) begin bad++; $display("FAIL rd_invalid got=%b/%h exp=0/0", cif.read_valid_o, cif.read_value_o); end
      total++; if (cif.search_resp_o !== 1'b1 || cif.search_hit_o !== 1'b0 || cif.search_index_o !== 5'd0) begin bad++; $display("FAIL srch_invalid got=%b/%b/%0d exp=1/0/0", cif.search_resp_o, cif.search_hit_o, cif.search_index_o); end
      cif.search_en_i = 1'b1; cif.search_data_i = 32'h101F;
      tick();
      total++; if (cif.search_hit_o !== 1'b1 || cif.search_index_o !== 5'd31) begin bad++; $display("FAIL srch_top got=%b/%0d exp=1/31", cif.search_hit_o, cif.search_index_o); end
   endtask

   task automatic test_reset_squash();
      cif.search_en_i = 1'b1; cif.search_data_i = 32'h101F;
      tick();
      total++; if (cif.search_resp_o !== 1'b1 || cif.search_hit_o !== 1'b1) begin bad++; $display("FAIL pre_rst_srch got=%b/%b exp=1/1", cif.search_resp_o, cif.search_hit_o); end
      rst = 1'b1;
      cif.search_en_i = 1'b1; cif.search_data_i = 32'h101F;
      cif.write_en_i = 1'b1; cif.write_index_i = 5'd9; cif.write_data_i = 32'h99;
      cif.read_en_i = 1'b1; cif.read_index_i = 5'd31;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      total++; if (cif.search_resp_o !== 1'b0 || cif.search_hit_o !== 1'b0 || cif.search_index_o !== 5'd0) begin bad++; $display("FAIL sq_search got=%b/%b/%0d exp=0/0/0", cif.search_resp_o, cif.search_hit_o, cif.search_index_o); end
      total++; if (cif.count_o !== 6'd0 || cif.empty_o !== 1'b1 || cif.full_o !== 1'b0) begin bad++; $display("FAIL sq_count got=%0d/%b/%b exp=0/1/0", cif.count_o, cif.empty_o, cif.full_o); end
      total++; if (cif.read_valid_o !== 1'b0 || cif.read_value_o !== 32'h0) begin bad++; $display("FAIL sq_read got=%b/%h exp=0/0", cif.read_valid_o, cif.read_value_o); end
      cif.read_en_i = 1'b1; cif.read_index_i = 5'd31;
      tick();
      total++; if (cif.read_valid_o !== 1'b0 || cif.read_value_o !== 32'h0) begin bad++; $display("FAIL post_rst_read got=%b/%h exp=0/0", cif.read_valid_o, cif.read_value_o); end
      cif.read_en_i = 1'b1; cif.read_index_i = 5'd9;
      tick();
      total++; if (cif.read_valid_o !== 1'b0 || cif.count_o !== 6'd0) begin bad++; $display("FAIL dropped_write got=%b/%0d exp=0/0", cif.read_valid_o, cif.count_o); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle();
      test_reset();
      test_write_read();
      test_search();
      test_same_cycle();
      test_reset();
      test_write_inv_collide();
      test_reset();
      test_fill();
      test_reset_squash();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
